tag_array_port_arbiter: RTL and testbench
=========================================

# tag_array_port_arbiter

Sequencer and two-port round-robin arbiter in front of one single-port RW0 tag SRAM macro: 2^ADDR_W sets, WAYS ways of WAY_W bits, per-way write mask, 1-cycle registered read.
- Clears every set to zero after reset or on a flush request.
- Then shares the macro between two valid/ready requesters, such as refill/writeback and lookup.
- Returns read data to the requester that issued each read.

## Interface
- ADDR_W, 6, set-index width; the macro has 2^ADDR_W sets
- WAYS, 4, number of ways; also the write-mask width
- WAY_W, 24, bits per way; DATA_W = WAYS*WAY_W
- clock  in  1  sole clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- flush  in  1  request to re-clear the whole array
- init_busy  out  1  high while the clear sweep runs
- pN_valid  in  1  request valid, N in {0,1}
- pN_ready  out  1  request accepted this cycle
- pN_addr  in  ADDR_W  set index
- pN_write  in  1  1 = write, 0 = read
- pN_wmask  in  WAYS  per-way write enable; ignored for reads
- pN_wdata  in  DATA_W  write data; ignored for reads
- pN_resp_valid  out  1  read data valid
- pN_resp_data  out  DATA_W  read data
- sram_en, sram_wmode  out  1  to macro RW0_en / RW0_wmode
- sram_addr  out  ADDR_W  to macro RW0_addr
- sram_wmask  out  WAYS  to macro RW0_wmask
- sram_wdata  out  DATA_W  to macro RW0_wdata
- sram_rdata  in  DATA_W  from macro RW0_rdata

## Operation
States:
- INIT: clear sweep.
- ARB: arbitration.

Registers:
- state
- sweep counter cnt, ADDR_W bits
- rr_ptr: preferred port
- resp_pend[1:0]

INIT:
- Each cycle drives sram_en=1, sram_wmode=1, sram_addr=cnt, sram_wmask=all ones, sram_wdata=0.
- cnt increments each cycle.
- When cnt = 2^ADDR_W-1, the next state is ARB and cnt returns to 0.
- init_busy=1, p0_ready=p1_ready=0.
- flush sampled high in INIT restarts the sweep: cnt <= 0, state stays INIT.

ARB, grant selection:
- Exactly one valid requester: it is granted.
- Both valid: the port indicated by rr_ptr is granted.
- After any grant, rr_ptr <= the non-granted port index.
- No grant: rr_ptr holds.

ARB, granted request:
- pN_ready=1.
- sram_en=1, sram_wmode=pN_write, sram_addr=pN_addr, sram_wmask=pN_wmask, sram_wdata=pN_wdata.
- pN_ready and all sram_* outputs are combinational from the valids, rr_ptr and state.

ARB, no grant:
- sram_en=0; other sram_* outputs are don't-care, driven 0.

Reads:
- An accepted read sets resp_pend[N] for exactly the next cycle.
- pN_resp_valid = resp_pend[N].
- pN_resp_data = sram_rdata, passed through unregistered, valid only while pN_resp_valid is high.

Writes produce no response.

flush sampled high in ARB:
- The current cycle's grant proceeds normally.
- state <= INIT, cnt <= 0.
- A read accepted in that cycle still returns its response in the first INIT cycle.

Reset (any cycle, including mid-sweep or with a response pending):
- state <= INIT, cnt <= 0, rr_ptr <= 0, resp_pend <= 0.

Requester rules:
- pN_valid may be asserted while ready is low.
- The requester holds its fields stable until ready.
- The arbiter never grants both ports in one cycle.

## Timing
Output values from the cycle after reset is sampled high:
- init_busy=1.
- pN_ready=0, pN_resp_valid=0.
- sram_en=1, writing set 0.

Sweep length:
- The sweep occupies 2^ADDR_W cycles (64 by default), one set per cycle, in ascending order.
- The first grant is possible in cycle 2^ADDR_W after reset deasserts.
- init_busy falls in that same cycle.

Latencies:
- Request to macro: 0 cycles (same cycle as ready).
- Read response: exactly 1 cycle after acceptance.
- Throughput: one access per cycle.

Ordering:
- A write to set S accepted in cycle t, followed by a read of S accepted in cycle t+1, returns the written data in cycle t+2.

Throughput under contention:
- With both ports continuously valid, grants alternate every cycle.
- Each port receives one grant per 2 cycles; neither port starves.

## Test plan
- Reset held 3 cycles, then released:
  - init_busy is high for exactly 64 cycles.
  - sram_addr steps 0..63 with wmask=4'hF, wdata=0.
  - A p1 read of set 17 is issued after the sweep; its response is 96'h0.
- Port-0 write, addr 5, mask 4'b0101, data way0=24'hABCDEF and way2=24'h123456, then a port-1 read of addr 5 in the next cycle:
  - p1_resp_valid rises 1 cycle after the read is accepted.
  - Data: way0=ABCDEF, way1=0, way2=123456, way3=0.
- Both ports held valid with reads for 8 cycles:
  - Grants alternate 0,1,0,1,... starting with port 0 after reset.
  - Each resp_valid appears only on the issuing port.
- flush pulsed in the same cycle a p0 read of addr 9 is accepted:
  - p0_resp_valid occurs in the next cycle with the stored data.
  - init_busy is then high for 64 cycles and ready stays low.
  - A later read of addr 9 returns 0.
- flush pulsed again at sweep cnt=40:
  - The sweep restarts at 0, giving 105 total busy cycles from the first flush.
- Reset asserted one cycle after a read is accepted:
  - resp_valid is 0 after reset.
  - The sweep restarts from set 0.
  - rr_ptr is back to 0, so the first contended grant goes to port 0.

Source files
------------

// File: rtl/tag_array_port_arbiter_if.sv
// tag_array_port_arbiter_if: one valid/ready requester port with its read-response return path
interface tag_array_port_arbiter_if #(
    parameter int ADDR_W = 6,
    parameter int WAYS   = 4,
    parameter int WAY_W  = 24
);
    logic                    valid;
    logic                    ready;
    logic                    write;
    logic [ADDR_W-1:0]       addr;
    logic [WAYS-1:0]         wmask;
    logic [WAYS*WAY_W-1:0]   wdata;
    logic                    resp_valid;
    logic [WAYS*WAY_W-1:0]   resp_data;
    modport master (output valid, write, addr, wmask, wdata, input ready, resp_valid, resp_data);
    modport slave  (input valid, write, addr, wmask, wdata, output ready, resp_valid, resp_data);
endinterface

// File: rtl/tag_array_port_arbiter.sv
// tag_array_port_arbiter: clear sweep plus two-port round-robin arbiter in front of a single-port tag SRAM
module tag_array_port_arbiter #(
    parameter int ADDR_W = 6,
    parameter int WAYS   = 4,
    parameter int WAY_W  = 24,
    localparam int DATA_W = WAYS * WAY_W
) (
    input  logic                     RW0_clk,
    input  logic                     rst,
    input  logic                     flush,
    output logic                     init_busy,
    tag_array_port_arbiter_if.slave  p0,
    tag_array_port_arbiter_if.slave  p1,
    output logic                     sram_en,
    output logic                     sram_wmode,
    output logic [ADDR_W-1:0]        sram_addr,
    output logic [WAYS-1:0]          sram_wmask,
    output logic [DATA_W-1:0]        sram_wdata,
    input  logic [DATA_W-1:0]        sram_rdata
);
    typedef enum logic {INIT, ARB} state_t;
    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              rr_ptr;
    logic [1:0]        resp_pend;
    logic              g0, g1;
    assign g0 = state == ARB && p0.valid && (!p1.valid || !rr_ptr);
    assign g1 = state == ARB && p1.valid && (!p0.valid || rr_ptr);
    assign p0.resp_valid = resp_pend[0];
    assign p1.resp_valid = resp_pend[1];
    assign p0.resp_data  = sram_rdata;
    assign p1.resp_data  = sram_rdata;
    // state register with sweep counter, preferred-port pointer and one-cycle read tags
    always_ff @(posedge RW0_clk) begin
        if (rst) begin
            state     <= INIT;
            cnt       <= '0;
            rr_ptr    <= 1'b0;
            resp_pend <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rr_ptr    <= g0 ? 1'b1 : g1 ? 1'b0 : rr_ptr;
            resp_pend <= {g1 && !p1.write, g0 && !p0.write};
        end
    end
    // sweep runs through the last set then hands over to arbitration; flush restarts it from either state
    always_comb begin
        state_nxt = flush || (state == INIT && cnt != '1) ? INIT : ARB;
        cnt_nxt   = state == INIT && !flush ? cnt + 1'b1 : '0;
    end
    // macro drive: zero-fill writes while sweeping, otherwise the granted requester passes straight through
    always_comb begin
        init_busy  = state == INIT;
        p0.ready   = g0;
        p1.ready   = g1;
        sram_en    = init_busy || g0 || g1;
        sram_wmode = init_busy || (g0 ? p0.write : g1 && p1.write);
        sram_addr  = init_busy ? cnt : g0 ? p0.addr : g1 ? p1.addr : '0;
        sram_wmask = init_busy ? '1 : g0 ? p0.wmask : g1 ? p1.wmask : '0;
        sram_wdata = g0 ? p0.wdata : g1 ? p1.wdata : '0;
    end
endmodule

// File: tb/tb_tag_array_port_arbiter.sv
// tb_tag_array_port_arbiter: randomized and directed checks against a set-level reference model
module tb_tag_array_port_arbiter;
    localparam int AW = 6, NW = 4, WW = 24, DW = NW * WW, NSET = 1 << AW;
    logic clk = 0, rst = 1, flush = 0, init_busy;
    logic sram_en, sram_wmode;
    logic [AW-1:0] sram_addr;
    logic [NW-1:0] sram_wmask;
    logic [DW-1:0] sram_wdata, sram_rdata;
    logic [DW-1:0] macro [NSET];
    logic v [2], wr [2];
    logic [AW-1:0] ad [2];
    logic [NW-1:0] mk [2];
    logic [DW-1:0] wd [2];
    logic [DW-1:0] ref_mem [NSET];
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] got_resp [2];
    logic got_rv [2];
    bit m_init;
    int m_idx, m_pref, m_pend, last_grant, busy_cnt, checks, fails;

    tag_array_port_arbiter_if #(.ADDR_W(AW), .WAYS(NW), .WAY_W(WW)) p0_if ();
    tag_array_port_arbiter_if #(.ADDR_W(AW), .WAYS(NW), .WAY_W(WW)) p1_if ();
    assign p0_if.valid = v[0];
    assign p0_if.write = wr[0];
    assign p0_if.addr  = ad[0];
    assign p0_if.wmask = mk[0];
    assign p0_if.wdata = wd[0];
    assign p1_if.valid = v[1];
    assign p1_if.write = wr[1];
    assign p1_if.addr  = ad[1];
    assign p1_if.wmask = mk[1];
    assign p1_if.wdata = wd[1];

    tag_array_port_arbiter #(.ADDR_W(AW), .WAYS(NW), .WAY_W(WW)) dut (
        .RW0_clk(clk), .rst(rst), .flush(flush), .init_busy(init_busy),
        .p0(p0_if), .p1(p1_if),
        .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
        .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    // behavioural single-port macro: masked write, registered read
    always @(posedge clk) begin
        if (sram_en === 1'b1) begin
            if (sram_wmode) begin
                for (int i = 0; i < NW; i++)
                    if (sram_wmask[i]) macro[sram_addr][i*WW +: WW] <= sram_wdata[i*WW +: WW];
            end else sram_rdata <= macro[sram_addr];
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic req(input int p, input logic w, input logic [AW-1:0] a, input logic [NW-1:0] m, input logic [DW-1:0] d);
        v[p] = 1; wr[p] = w; ad[p] = a; mk[p] = m; wd[p] = d;
    endtask

    task automatic idle();
        v[0] = 0; v[1] = 0;
    endtask

    // one clock: predict and compare at negedge, then advance the model to the next cycle
    task automatic cycle();
        int g;
        @(negedge clk);
        got_rv[0] = p0_if.resp_valid;
        got_rv[1] = p1_if.resp_valid;
        got_resp[0] = p0_if.resp_data;
        got_resp[1] = p1_if.resp_data;
        g = -1;
        if (!rst) begin
            if (init_busy === 1'b1) busy_cnt++;
            chk("init_busy", init_busy, m_init);
            chk("resp_valid0", p0_if.resp_valid, m_pend == 0);
            chk("resp_valid1", p1_if.resp_valid, m_pend == 1);
            if (m_pend >= 0) chk("resp_data", m_pend == 1 ? p1_if.resp_data : p0_if.resp_data, m_pend_data);
            if (m_init) begin
                chk("sweep_en", sram_en, 1);
                chk("sweep_wmode", sram_wmode, 1);
                chk("sweep_addr", sram_addr, m_idx);
                chk("sweep_wmask", sram_wmask, 4'hF);
                chk("sweep_wdata", sram_wdata, 0);
                chk("sweep_ready0", p0_if.ready, 0);
                chk("sweep_ready1", p1_if.ready, 0);
            end else begin
                g = (v[0] && v[1]) ? m_pref : v[0] ? 0 : v[1] ? 1 : -1;
                chk("ready0", p0_if.ready, g == 0);
                chk("ready1", p1_if.ready, g == 1);
                chk("sram_en", sram_en, g >= 0);
                if (g >= 0) begin
                    chk("sram_wmode", sram_wmode, wr[g]);
                    chk("sram_addr", sram_addr, ad[g]);
                    if (wr[g]) begin
                        chk("sram_wmask", sram_wmask, mk[g]);
                        chk("sram_wdata", sram_wdata, wd[g]);
                    end
                end
            end
        end
        last_grant = g;
        if (rst) begin
            m_init = 1; m_idx = 0; m_pref = 0; m_pend = -1;
        end else begin
            m_pend = -1;
            if (g >= 0) begin
                m_pref = 1 - g;
                if (wr[g]) begin
                    for (int i = 0; i < NW; i++)
                        if (mk[g][i]) ref_mem[ad[g]][i*WW +: WW] = wd[g][i*WW +: WW];
                end else begin
                    m_pend = g;
                    m_pend_data = ref_mem[ad[g]];
                end
            end
            if (m_init) begin
                ref_mem[m_idx] = '0;
                if (flush) m_idx = 0;
                else if (m_idx == NSET - 1) begin m_idx = 0; m_init = 0; end
                else m_idx++;
            end else if (flush) begin
                m_init = 1; m_idx = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] exp5;
        checks = 0; fails = 0; busy_cnt = 0;
        m_init = 1; m_idx = 0; m_pref = 0; m_pend = -1;
        idle();
        for (int p = 0; p < 2; p++) begin wr[p] = 0; ad[p] = 0; mk[p] = 0; wd[p] = 0; end
        // reset, then a full sweep
        repeat (3) cycle();
        rst = 0;
        busy_cnt = 0;
        repeat (70) cycle();
        chk("busy_len_reset", busy_cnt, 64);
        req(1, 0, 17, 0, 0); cycle(); idle(); cycle();
        chk("rd17_valid", got_rv[1], 1);
        chk("rd17_data", got_resp[1], 0);
        // masked write then read-after-write from the other port
        req(0, 1, 5, 4'b0101, {24'hFFFFFF, 24'h123456, 24'hFFFFFF, 24'hABCDEF}); cycle();
        idle(); req(1, 0, 5, 0, 0); cycle();
        idle(); cycle();
        exp5 = {24'h000000, 24'h123456, 24'h000000, 24'hABCDEF};
        chk("raw_valid", got_rv[1], 1);
        chk("raw_valid_other", got_rv[0], 0);
        chk("raw_data", got_resp[1], exp5);
        // contention: grants must alternate
        req(0, 0, 5, 0, 0); req(1, 0, 17, 0, 0);
        cycle();
        for (int i = 1; i < 8; i++) begin
            int prev;
            prev = last_grant;
            cycle();
            chk("alternate", last_grant, 1 - prev);
        end
        idle(); cycle();
        // flush together with a read of set 9
        req(0, 1, 9, 4'hF, {4{24'h5A5A5A}}); cycle();
        req(0, 0, 9, 0, 0); flush = 1; cycle();
        idle(); flush = 0; busy_cnt = 0;
        cycle();
        chk("flush_rd_valid", got_rv[0], 1);
        chk("flush_rd_data", got_resp[0], {4{24'h5A5A5A}});
        repeat (69) cycle();
        chk("busy_len_flush", busy_cnt, 64);
        req(0, 0, 9, 0, 0); cycle(); idle(); cycle();
        chk("rd9_cleared", got_resp[0], 0);
        // flush again mid-sweep at cnt=40
        flush = 1; cycle(); flush = 0; busy_cnt = 0;
        repeat (40) cycle();
        flush = 1; cycle(); flush = 0;
        repeat (70) cycle();
        chk("busy_len_reflush", busy_cnt, 105);
        // reset right after an accepted read
        req(0, 0, 3, 0, 0); cycle();
        idle(); rst = 1; cycle(); rst = 0;
        cycle();
        chk("rv_after_rst", got_rv[0], 0);
        repeat (64) cycle();
        req(0, 0, 1, 0, 0); req(1, 0, 2, 0, 0); cycle();
        chk("rr_after_rst", last_grant, 0);
        idle(); cycle();
        // random traffic with occasional flushes
        for (int n = 0; n < 800; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!(v[p] && last_grant != p)) begin
                    v[p] = ($urandom_range(3) != 0);
                    wr[p] = $urandom_range(1);
                    ad[p] = AW'($urandom_range(7));
                    mk[p] = NW'($urandom);
                    wd[p] = {$urandom, $urandom, $urandom};
                end
            end
            flush = ($urandom_range(199) == 0);
            cycle();
        end
        flush = 0; idle(); cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
